freq_meter: RTL and testbench
=============================

Name: freq_meter

Overview:
- Measures the frequency of a single-bit input, such as the prescaler `out` tick or any asynchronous clock, by counting its rising edges during a fixed gate window timed from `clk`.
- Consumer end of the prescaler interface.
- Used on-board to verify generated clocks (AY/UART/CPU) and exposed to software as a readable count.
- Free-running back-to-back windows while enabled; each completed window produces one latched result and a one-cycle valid strobe.

Parameters:
- GATE_CYCLES, 25000: gate window length in `clk` cycles (1 ms at 25 MHz); must be >= 2.
- COUNT_W, 16: width of the edge counter and result.
- SYNC_STAGES, 2: synchronizer flip-flops on `sig_in`; must be >= 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- sig_in  in  1  signal under measurement; asynchronous to `clk`.
- enable  in  1  1 = measure continuously; 0 = idle and clear.
- count  out  COUNT_W  edges counted in the last completed window.
- overflow  out  1  last completed window saturated `count`.
- valid  out  1  one-cycle strobe: new `count`/`overflow` latched.
- busy  out  1  1 while in ARM or MEASURE.

Behaviour:
- Reset (reset = 0, async):
  - All state cleared.
  - count = 0, overflow = 0, valid = 0, busy = 0, FSM = IDLE.
  - Synchronizer flops are cleared to 0.
- Input path:
  - SYNC_STAGES-deep synchronizer, then a one-flop edge detector.
  - `rise` = synced & ~synced_d.
  - A pulse on `sig_in` shorter than one `clk` period may be missed. This is acceptable.
  - Valid measurement requires sig_in frequency < clk/2.
- FSM states:
  - IDLE: busy = 0, counters held at 0. Goes to ARM when enable = 1.
  - ARM:
    - Lasts SYNC_STAGES+1 cycles to flush stale synchronizer contents; edges in this time are discarded.
    - busy = 1.
    - Then goes to MEASURE with gate_cnt = GATE_CYCLES-1 and edge_cnt = 0.
  - MEASURE:
    - Each cycle, edge_cnt increments when rise = 1, saturating at 2^COUNT_W-1.
    - Saturation sets a sticky ovf_flag for the window.
    - gate_cnt decrements each cycle.
    - The cycle with gate_cnt == 0 is the last sampled cycle, and an edge on that cycle is counted.
    - On the next clock edge:
      - count <= final edge_cnt; overflow <= ovf_flag; valid <= 1 for exactly one cycle.
      - gate_cnt reloads and edge_cnt/ovf_flag clear, and MEASURE continues with no dead cycle.
    - First valid occurs SYNC_STAGES+1+GATE_CYCLES cycles after the first enable = 1 cycle. Later valids occur every GATE_CYCLES cycles.
- enable falling (any state):
  - Next state IDLE, with in-progress window discarded and no valid.
  - count/overflow keep the last completed result.
  - Re-enable always passes through ARM.
- Reset during a window: everything is cleared, including count/overflow; no valid.
- Widths: gate_cnt width = $clog2(GATE_CYCLES). No arithmetic wraps; edge_cnt saturates and never wraps to 0.
- No input handshake: `valid` is not back-pressured. A consumer that misses the strobe reads the held `count`.

Optional Feature:
- Macro: FREQ_METER_MINMAX_EN.
- When defined:
  - Adds outputs count_min and count_max [COUNT_W-1:0].
  - Both are updated on each valid: count_min = min of results, count_max = max of results.
  - Both reset to 0. On entering ARM from IDLE, count_min loads 2^COUNT_W-1 and count_max loads 0.
  - The first result of a run therefore sets both.
  - Overflowed windows are included as the saturated value.
- When undefined: the ports and their logic do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset/idle: hold reset = 0 with enable = 1 and sig_in toggling -> count = 0, valid = 0, busy = 0. Release reset -> busy = 1 next cycle, first valid exactly GATE_CYCLES+SYNC_STAGES+1 cycles later.
- Exact count: sig_in = clk/4, generated synchronously as a 50% square wave; default parameters -> every valid gives count = 6250, overflow = 0, and valid period = 25000 cycles.
- Prescaler loopback: feed prescaler(IN_FREQ = 25000000, OUT_FREQ = 1789773).out into sig_in -> each count is 1789 or 1790, and the mean over 10 windows is within +/-1 of 1789.8.
- Saturation: COUNT_W = 8, sig_in = clk/4 -> count = 255, overflow = 1 each window. Switch to sig_in = clk/256 (about 97 edges) -> next full window has overflow = 0.
- Abort: deassert enable halfway through the second window -> no valid, count holds the first window's value, busy = 0 next cycle. Re-enable -> full ARM + window before the next valid. Repeat with reset pulsed low mid-window -> count = 0 immediately (async).
- MINMAX_EN: alternate sig_in between clk/4 and clk/8 across windows -> count_min = 3125, count_max = 6250. Disable and re-enable -> both reinitialized before the first new result.

Source files
------------

// File: rtl/freq_meter.sv
// Gate-window frequency meter: counts synchronized rising edges of sig_in per GATE_CYCLES clk window.
// Optional running min/max of results when FREQ_METER_MINMAX_EN is defined.
module freq_meter #(
   parameter int GATE_CYCLES = 25000,
   parameter int COUNT_W     = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               sig_in,
   input  logic               enable,
   output logic [COUNT_W-1:0] count,
   output logic               overflow,
   output logic               valid,
   output logic               busy
`ifdef FREQ_METER_MINMAX_EN
   ,
   output logic [COUNT_W-1:0] count_min,
   output logic [COUNT_W-1:0] count_max
`endif
);

   localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam int AW = $clog2(SYNC_STAGES + 2);
   localparam logic [GW-1:0]      GATE_LOAD = GW'(GATE_CYCLES - 1);
   localparam logic [AW-1:0]      ARM_LAST  = AW'(SYNC_STAGES);
   localparam logic [COUNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

   state_t             state, state_nxt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic               synced_d;
   logic               rise;
   logic [AW-1:0]      arm_cnt;
   logic [GW-1:0]      gate_cnt;
   logic [COUNT_W-1:0] edge_cnt, edge_inc;
   logic               ovf_flag, ovf_nxt;
   logic               arm_start, win_end;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q   <= '0;
         synced_d <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], sig_in};
         synced_d <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~synced_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      arm_start = 1'b0;
      win_end   = 1'b0;
      // The edge landing on the final gate cycle still counts, so the latched
      // result is taken from the incremented value rather than edge_cnt.
      edge_inc  = (rise && edge_cnt != CNT_MAX) ? edge_cnt + 1'b1 : edge_cnt;
      ovf_nxt   = ovf_flag | (rise & (edge_cnt == CNT_MAX));
      if (!enable) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               state_nxt = ARM;
               arm_start = 1'b1;
            end
            ARM:     if (arm_cnt == ARM_LAST) state_nxt = MEASURE;
            MEASURE: if (gate_cnt == '0) win_end = 1'b1;
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         arm_cnt  <= '0;
         gate_cnt <= '0;
         edge_cnt <= '0;
         ovf_flag <= 1'b0;
         count    <= '0;
         overflow <= 1'b0;
         valid    <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (!enable || state == IDLE) begin
            arm_cnt  <= '0;
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
         end else if (state == ARM) begin
            arm_cnt  <= arm_cnt + 1'b1;
            gate_cnt <= GATE_LOAD;
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
         end else if (win_end) begin
            count    <= edge_inc;
            overflow <= ovf_nxt;
            valid    <= 1'b1;
            gate_cnt <= GATE_LOAD;
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
         end else begin
            gate_cnt <= gate_cnt - 1'b1;
            edge_cnt <= edge_inc;
            ovf_flag <= ovf_nxt;
         end
      end
   end

`ifdef FREQ_METER_MINMAX_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_min <= '0;
         count_max <= '0;
      end else if (arm_start) begin
         count_min <= CNT_MAX;
         count_max <= '0;
      end else if (win_end) begin
         if (edge_inc < count_min) count_min <= edge_inc;
         if (edge_inc > count_max) count_max <= edge_inc;
      end
   end
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: edge counts per window come from a sample-history model.
module tb_freq_meter;

   localparam int G    = 400;
   localparam int CW   = 7;
   localparam int S    = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          sig_in = 1'b0;
   logic          enable = 1'b0;
   logic [CW-1:0] count;
   logic          overflow, valid, busy;
`ifdef FREQ_METER_MINMAX_EN
   logic [CW-1:0] count_min, count_max;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit hist [0:65535];
   int mode = 0;
   int per = 4;
   int phase = 0;
   int k0 = 0;
   int win = 0;
   int mm_min = 0;
   int mm_max = 0;
   int last_exp = 0;

   freq_meter #(.GATE_CYCLES(G), .COUNT_W(CW), .SYNC_STAGES(S)) dut (
      .clk(clk), .reset(reset), .sig_in(sig_in), .enable(enable),
      .count(count), .overflow(overflow), .valid(valid), .busy(busy)
`ifdef FREQ_METER_MINMAX_EN
      , .count_min(count_min), .count_max(count_max)
`endif
   );

   always #5 clk = ~clk;

   // hist[i] is the sig_in value sampled by the DUT at posedge number i
   always @(posedge clk) begin
      hist[cyc] = sig_in;
      cyc++;
   end

   always @(negedge clk) begin
      case (mode)
         1: begin
            sig_in = (phase < per / 2);
            phase  = (phase + 1) % per;
         end
         2:       sig_in = 1'($urandom_range(0, 1));
         default: sig_in = 1'b0;
      endcase
   end

   function automatic int model_edges(input int first, input int last);
      int n = 0;
      for (int t = first; t <= last; t++)
         if (t > 0 && hist[t] && !hist[t-1]) n++;
      return n;
   endfunction

   task automatic start_run();
      @(negedge clk);
      enable = 1'b1;
      reset  = 1'b1;
      k0     = cyc;
      win    = 0;
      mm_min = CMAX;
      mm_max = 0;
   endtask

   task automatic wait_valid(input int budget, output int idx, output bit ok);
      ok  = 1'b0;
      idx = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (valid === 1'b1) begin
            ok  = 1'b1;
            idx = cyc - 1;
            return;
         end
      end
   endtask

   task automatic check_windows(input int n, input int exp_const, input int exp_ovf);
      int idx, e, exp_idx;
      bit ok;
      logic [CW-1:0] exp_c;
      logic exp_o;
      for (int w = 0; w < n; w++) begin
         wait_valid(G + S + 4, idx, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL valid_timeout: got no valid expected valid within %0d cycles", G + S + 4);
            return;
         end
         exp_idx = k0 + S + 1 + (win + 1) * G;
         checks++;
         if (idx !== exp_idx) begin
            errors++;
            $display("FAIL valid_time: got edge %0d expected edge %0d", idx, exp_idx);
         end
         e        = model_edges(k0 + 2 + win * G, k0 + 1 + (win + 1) * G);
         exp_c    = CW'((e > CMAX) ? CMAX : e);
         exp_o    = (e > CMAX);
         last_exp = int'(exp_c);
         checks++;
         if (count !== exp_c) begin
            errors++;
            $display("FAIL count: got %0d expected %0d (window %0d)", count, exp_c, win);
         end
         checks++;
         if (overflow !== exp_o) begin
            errors++;
            $display("FAIL overflow: got %0b expected %0b (window %0d)", overflow, exp_o, win);
         end
         if (exp_const >= 0) begin
            checks++;
            if (count !== CW'(exp_const)) begin
               errors++;
               $display("FAIL count_const: got %0d expected %0d", count, exp_const);
            end
         end
         if (exp_ovf >= 0) begin
            checks++;
            if (overflow !== 1'(exp_ovf)) begin
               errors++;
               $display("FAIL overflow_const: got %0b expected %0d", overflow, exp_ovf);
            end
         end
         if (last_exp < mm_min) mm_min = last_exp;
         if (last_exp > mm_max) mm_max = last_exp;
`ifdef FREQ_METER_MINMAX_EN
         checks++;
         if (count_min !== CW'(mm_min) || count_max !== CW'(mm_max)) begin
            errors++;
            $display("FAIL minmax: got %0d/%0d expected %0d/%0d", count_min, count_max, mm_min, mm_max);
         end
`endif
         win++;
         @(negedge clk);
         checks++;
         if (valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_width: got %0b expected 0", valid);
         end
      end
   endtask

   task automatic test_reset();
      reset  = 1'b0;
      enable = 1'b1;
      mode   = 2;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (count !== '0 || valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got count=%0d valid=%0b busy=%0b expected 0/0/0", count, valid, busy);
         end
      end
      start_run();
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_after_release: got %0b expected 1", busy);
      end
      check_windows(2, -1, -1);
   endtask

   task automatic test_exact();
      enable = 1'b0;
      mode   = 1;
      per    = 4;
      phase  = 0;
      repeat (8) @(negedge clk);
      start_run();
      check_windows(3, G / 4, 0);
   endtask

   task automatic test_saturation();
      mode = 1;
      per  = 3;
      check_windows(2, CMAX, 1);
      per   = 16;
      phase = 0;
      check_windows(1, -1, -1);
      check_windows(2, G / 16, 0);
   endtask

   task automatic test_random();
      mode = 2;
      check_windows(4, -1, -1);
   endtask

   task automatic test_abort();
      int held, seen;
      mode = 2;
      enable = 1'b0;
      repeat (3) @(negedge clk);
      start_run();
      check_windows(1, -1, -1);
      held = last_exp;
      repeat (G / 2) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_busy: got %0b expected 0", busy);
      end
      seen = 0;
      for (int i = 0; i < G + S + 4; i++) begin
         @(negedge clk);
         if (valid === 1'b1) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL abort_no_valid: got %0d strobes expected 0", seen);
      end
      checks++;
      if (count !== CW'(held)) begin
         errors++;
         $display("FAIL abort_hold: got %0d expected %0d", count, held);
      end
      start_run();
      check_windows(1, -1, -1);
      repeat (G / 2) @(negedge clk);
      #1 reset = 1'b0;
      #1;
      checks++;
      if (count !== '0 || overflow !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got count=%0d ovf=%0b valid=%0b busy=%0b expected 0/0/0/0",
                  count, overflow, valid, busy);
      end
`ifdef FREQ_METER_MINMAX_EN
      checks++;
      if (count_min !== '0 || count_max !== '0) begin
         errors++;
         $display("FAIL reset_minmax: got %0d/%0d expected 0/0", count_min, count_max);
      end
`endif
      start_run();
      check_windows(1, -1, -1);
   endtask

   task automatic test_alternate();
      mode = 1;
      for (int i = 0; i < 4; i++) begin
         check_windows(1, -1, -1);
         per   = (per == 4) ? 8 : 4;
         phase = 0;
      end
      enable = 1'b0;
      repeat (3) @(negedge clk);
      start_run();
      @(negedge clk);
`ifdef FREQ_METER_MINMAX_EN
      checks++;
      if (count_min !== CW'(CMAX) || count_max !== '0) begin
         errors++;
         $display("FAIL minmax_rearm: got %0d/%0d expected %0d/0", count_min, count_max, CMAX);
      end
`endif
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL rearm_busy: got %0b expected 1", busy);
      end
      check_windows(2, -1, -1);
   endtask

   initial begin
      test_reset();
      test_exact();
      test_saturation();
      test_random();
      test_abort();
      test_alternate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
